// File: rtl/c0_pkg.sv
// Shared definitions for the instruction fetch/decode sequencer: field positions,
// class codes, NOP/halt encodings, FSM states and the decoded control bundle.
package c0_pkg;

    localparam int CLS_HI  = 31;
    localparam int CLS_LO  = 30;
    localparam int MS_HI   = 29;
    localparam int MS_LO   = 28;
    localparam int IRS_BIT = 27;
    localparam int RS_HI   = 26;
    localparam int RS_LO   = 24;
    localparam int AR_HI   = 23;
    localparam int AR_LO   = 21;
    localparam int BS_HI   = 20;
    localparam int BS_LO   = 18;
    localparam int OP_HI   = 17;
    localparam int OP_LO   = 14;
    localparam int RSV_HI  = 13;
    localparam int RSV_LO  = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [1:0] {
        CLS_NOP = 2'b00,
        CLS_ALU = 2'b01,
        CLS_JMP = 2'b10,
        CLS_MEM = 2'b11
    } inst_class_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [7:0]  HALT_IMM = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       mem_inst;
        logic       alu_inst;
        logic       jmp_inst;
        logic [1:0] ms;
        logic       irs;
        logic [2:0] rs;
        logic [2:0] ar;
        logic [2:0] bs;
        logic [3:0] op;
        logic [7:0] imm;
    } ctrl_t;

    // NOP rewrites R0 with itself: MS=01 routes R0 back through the write path.
    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c     = '0;
        c.ms  = 2'b01;
        return c;
    endfunction

    function automatic logic is_halt_word(logic [31:0] w);
        return (inst_class_t'(w[CLS_HI:CLS_LO]) == CLS_NOP) && (w[IMM_HI:IMM_LO] == HALT_IMM);
    endfunction

endpackage

// File: rtl/inst_fields.sv
// Combinational split of an instruction word into the core control bundle.
module inst_fields
    import c0_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl
);

    logic unused_rsvd;
    assign unused_rsvd = ^ir[RSV_HI:RSV_LO];

    inst_class_t cls;
    assign cls = inst_class_t'(ir[CLS_HI:CLS_LO]);

    always_comb begin
        ctrl = nop_ctrl();
        if (cls != CLS_NOP) begin
            ctrl.mem_inst = (cls == CLS_MEM);
            ctrl.alu_inst = (cls == CLS_ALU);
            ctrl.jmp_inst = (cls == CLS_JMP);
            ctrl.ms       = ir[MS_HI:MS_LO];
            ctrl.irs      = ir[IRS_BIT];
            ctrl.rs       = ir[RS_HI:RS_LO];
            ctrl.ar       = ir[AR_HI:AR_LO];
            ctrl.bs       = ir[BS_HI:BS_LO];
            ctrl.op       = ir[OP_HI:OP_LO];
            ctrl.imm      = ir[IMM_HI:IMM_LO];
        end
    end

endmodule

// File: rtl/inst_fetch_decode.sv
// Fetches one word per step, decodes it and drives a SETUP/HIGH/LOW step clock into the core.
// Optional: define C0_HALT_EN to make a NOP with IMM=8'hFF park the sequencer in HALT.
module inst_fetch_decode
    import c0_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic [7:0]  ADDR_IN,
    output logic        MEM_REQ,
    output logic [7:0]  MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_DATA,
    output logic        CORE_CLK,
    output logic        MEM_INST,
    output logic        ALU_INST,
    output logic        JMP_INST,
    output logic        MS1,
    output logic        MS0,
    output logic        IRS,
    output logic        RS2,
    output logic        RS1,
    output logic        RS0,
    output logic        AR2,
    output logic        AR1,
    output logic        AR0,
    output logic        BS2,
    output logic        BS1,
    output logic        BS0,
    output logic [3:0]  OP,
    output logic [7:0]  IMM,
    output logic        HALTED
);

    state_t      state, state_nxt;
    logic [31:0] ir, ir_nxt;
    ctrl_t       ctrl_dec, ctrl_q;
    logic        core_clk_q, mem_req_q;
    logic [7:0]  mem_addr_q;
    logic        halt_step;
    logic        req_nxt;

    // Decoding the next IR lets the registered outputs be valid in the SETUP cycle itself.
    assign ir_nxt = (state == S_WAIT && MEM_ACK) ? MEM_DATA : ir;

    inst_fields u_fields (
        .ir   (ir_nxt),
        .ctrl (ctrl_dec)
    );

`ifdef C0_HALT_EN
    assign halt_step = is_halt_word(ir);
    assign HALTED    = (state == S_HALT);
`else
    assign halt_step = 1'b0;
    assign HALTED    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        unique case (state)
            S_IDLE:  if (RUN) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  if (MEM_ACK) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_HIGH;
            S_HIGH:  state_nxt = S_LOW;
            S_LOW: begin
                if (halt_step)  state_nxt = S_HALT;
                else if (RUN)   state_nxt = S_FETCH;
                else            state_nxt = S_IDLE;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        req_nxt = (state_nxt == S_FETCH) || (state_nxt == S_WAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            ir         <= NOP_WORD;
            ctrl_q     <= nop_ctrl();
            core_clk_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 8'h00;
        end else begin
            state      <= state_nxt;
            ir         <= ir_nxt;
            ctrl_q     <= ctrl_dec;
            core_clk_q <= (state_nxt == S_HIGH);
            mem_req_q  <= req_nxt;
            if (state_nxt == S_FETCH && state != S_FETCH)
                mem_addr_q <= ADDR_IN;
        end
    end

    assign CORE_CLK = core_clk_q;
    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;

    assign {MEM_INST, ALU_INST, JMP_INST, MS1, MS0, IRS,
            RS2, RS1, RS0, AR2, AR1, AR0, BS2, BS1, BS0, OP, IMM} = ctrl_q;

endmodule

// File: doc/inst_fetch_decode.md
INST_FETCH_DECODE -- requirements
Module: inst_fetch_decode

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port RUN, input, 1 bit: when 1, fetch/step continuously; when 0, finish the current step and then park in IDLE.
REQ-004 SHALL have port ADDR_IN, input, 8 bits: the core's instruction address (the core Addr output).
REQ-005 SHALL have ports MEM_REQ (output, 1 bit), MEM_ADDR (output, 8 bits), MEM_ACK (input, 1 bit) and MEM_DATA (input, 32 bits): the instruction-memory handshake.
REQ-006 SHALL have port CORE_CLK, output, 1 bit: the step clock driven into the core's CLK input.
REQ-007 SHALL have the following core control outputs, each registered: MEM_INST, ALU_INST, JMP_INST, MS1, MS0, IRS, RS2..RS0, AR2..AR0, BS2..BS0 (1 bit each), OP (4 bits) and IMM (8 bits).
REQ-008 SHALL have port HALTED, output, 1 bit: 1 while in the HALT state.

Function
REQ-009 SHALL decode the instruction word as follows: [31:30] class (00 NOP, 01 ALU, 10 JMP, 11 MEM); [29:28] MS1:MS0; [27] IRS; [26:24] RS; [23:21] AR; [20:18] BS; [17:14] OP; [13:8] reserved, ignored; [7:0] IMM.
REQ-010 SHALL decode the class field one-hot: ALU sets ALU_INST, JMP sets JMP_INST, MEM sets MEM_INST.
REQ-011 SHALL, for a NOP, drive all three *_INST outputs to 0, MS=01, RS=AR=000 and all other fields to 0, so that R0 is rewritten with itself.
REQ-012 SHALL implement the FSM states IDLE, FETCH, WAIT, SETUP, HIGH, LOW and HALT.
REQ-013 In IDLE, SHALL move to FETCH when RUN=1.
REQ-014 On entering FETCH, SHALL capture ADDR_IN into MEM_ADDR, assert MEM_REQ, and move to WAIT.
REQ-015 In WAIT, SHALL hold MEM_REQ and MEM_ADDR stable until it samples MEM_ACK=1; in that cycle it latches MEM_DATA into the IR, drives MEM_REQ to 0 in the next cycle, and moves to SETUP.
REQ-016 SHALL ignore MEM_ACK outside WAIT.
REQ-017 In SETUP, SHALL make the decoded outputs valid while CORE_CLK stays 0; this is one cycle of setup before the rising edge.
REQ-018 In HIGH, SHALL drive CORE_CLK=1 for exactly one CLK cycle; the core PC advances on this edge.
REQ-019 In LOW, SHALL drive CORE_CLK=0 for one cycle; the core registers write on this falling edge.
REQ-020 SHALL hold all control outputs unchanged from SETUP through the end of LOW.
REQ-021 From LOW, SHALL go to FETCH if RUN=1, otherwise to IDLE.
REQ-022 SHALL never drop RUN mid-step: a step always completes LOW before parking.
REQ-023 The minimum step latency SHALL be 5 CLK cycles: FETCH, WAIT (ack in its first cycle), SETUP, HIGH, LOW.
REQ-024 SHALL pass MEM_ADDR through unmodified; address wrap 8'hFF->8'h00 is the core's concern.

Reset
REQ-025 On RST=1, asynchronously: state=IDLE, CORE_CLK=0, MEM_REQ=0, MEM_ADDR=0, IR=NOP encoding, outputs=NOP decode (REQ-011), HALTED=0.
REQ-026 A reset asserted mid-step (including during HIGH) SHALL force CORE_CLK low immediately and abandon any outstanding memory request.
REQ-027 After RST deasserts, SHALL start from IDLE.

Configuration
REQ-028 With macro C0_HALT_EN defined, a NOP with IMM=8'hFF SHALL enter HALT after its LOW phase.
REQ-029 In HALT (C0_HALT_EN defined), SHALL keep HALTED=1, keep CORE_CLK=0, issue no requests, and exit only on RST.
REQ-030 Without C0_HALT_EN, that word SHALL be treated as an ordinary NOP, HALT SHALL be unreachable, and HALTED SHALL be tied to 0.

Structure
REQ-031 Package c0_pkg SHALL hold the instruction-field bit positions, the class codes, the NOP encoding, the 8'hFF halt immediate and the FSM state type.
REQ-032 A combinational sub-module inst_fields SHALL split the IR into the control signals; the FSM and registers SHALL live in inst_fetch_decode.

Verification
REQ-033 Release reset with RUN=1, ADDR_IN=8'h00 and memory acking in 1 cycle -> MEM_REQ with MEM_ADDR=8'h00; CORE_CLK is first high in the 4th cycle after FETCH entry.
REQ-034 Word 32'h4000_8005 (ALU, OP=0010, IMM=5) -> ALU_INST=1, OP=4'b0010, IMM=8'h05, held unchanged through HIGH and LOW.
REQ-035 MEM_ACK delayed 3 cycles -> MEM_REQ and MEM_ADDR stable for all 4 WAIT cycles, then exactly one CORE_CLK pulse.
REQ-036 RUN dropped during WAIT -> the step completes, then the FSM reaches IDLE; no further MEM_REQ until RUN=1.
REQ-037 RST pulsed during HIGH -> CORE_CLK=0 and MEM_REQ=0 immediately; outputs return to the NOP decode.
REQ-038 Word 32'h0000_00FF with C0_HALT_EN -> HALTED=1 after LOW and no further requests; without the macro -> fetch continues.
